// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default memory latency, default starvation limit,
// and the width of the internal down-counters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_ACC = 2'd1,
        ARB_D_ACC  = 2'd2
    } arb_state_t;

    localparam int MEM_LAT_DEF    = 2;
    localparam int ARB_STARVE_DEF = 4;

    // LAT and STARVE_MAX are both limited to 1..15, so 4 bits cover them.
    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory command/response signals.
// Latency: n/a (wires only).
// Backpressure: requests are held until their valid pulse; stalls tell the pipeline to freeze.
// Modports: slave = arbiter view (takes requests, drives memory commands);
//           master = environment view (CPU ports plus the memory model).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic              iIfReq;
    logic [ADDR_W-1:0] iIfAddr;
    logic [DATA_W-1:0] oIfData;
    logic              oIfValid;
    logic              oIfStall;
    // data port
    logic              iDReq;
    logic              iDWr;
    logic [ADDR_W-1:0] iDAddr;
    logic [DATA_W-1:0] iDWrData;
    logic [DATA_W-1:0] oDRdData;
    logic              oDValid;
    logic              oDStall;
    // memory side
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWrData;
    logic              oMemRd;
    logic              oMemWr;
    logic [DATA_W-1:0] iMemRdData;

    modport slave (
        input  iIfReq, iIfAddr, iDReq, iDWr, iDAddr, iDWrData, iMemRdData,
        output oIfData, oIfValid, oIfStall, oDRdData, oDValid, oDStall,
               oMemAddr, oMemWrData, oMemRd, oMemWr
    );

    modport master (
        output iIfReq, iIfAddr, iDReq, iDWr, iDAddr, iDWrData, iMemRdData,
        input  oIfData, oIfValid, oIfStall, oDRdData, oDValid, oDStall,
               oMemAddr, oMemWrData, oMemRd, oMemWr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and MEM-stage data accesses.
// Latency: request seen in IDLE -> strobes for LAT cycles -> valid pulse at LAT+1; one dead cycle between accesses.
// Backpressure: each port stalls (iReq & ~oValid) until its access completes; data has priority unless fetch is starved.
// Ports: clk, reset (sync, active high); bus = fetch port, data port and memory command/response (slave modport).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = MEM_LAT_DEF,
    parameter int STARVE_MAX = ARB_STARVE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [ARB_CNT_W-1:0] LAT_M1     = ARB_CNT_W'(LAT - 1);
    localparam logic [ARB_CNT_W-1:0] STARVE_LIM = ARB_CNT_W'(STARVE_MAX);

    arb_state_t           state_q,  state_d;
    logic [ARB_CNT_W-1:0] cnt_q,    cnt_d;
    logic [ARB_CNT_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]    addr_q,   addr_d;
    logic [DATA_W-1:0]    wdat_q,   wdat_d;
    logic                 rd_q,     rd_d;
    logic                 wr_q,     wr_d;
    logic [DATA_W-1:0]    if_dat_q, if_dat_d;
    logic [DATA_W-1:0]    d_dat_q,  d_dat_d;
    logic                 if_vld_q, if_vld_d;
    logic                 d_vld_q,  d_vld_d;

    // A port whose valid pulse is up is still holding the request it just
    // completed; ignore it this cycle so the access is not issued twice.
    logic if_req_m;
    logic d_req_m;
    assign if_req_m = bus.iIfReq & ~if_vld_q;
    assign d_req_m  = bus.iDReq  & ~d_vld_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        if_dat_d = if_dat_q;
        d_dat_d  = d_dat_q;
        if_vld_d = 1'b0;
        d_vld_d  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (if_req_m && (!d_req_m || starve_q == STARVE_LIM)) begin
                    state_d  = ARB_IF_ACC;
                    cnt_d    = LAT_M1;
                    addr_d   = bus.iIfAddr;
                    wdat_d   = '0;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    starve_d = '0;
                end else if (d_req_m) begin
                    state_d = ARB_D_ACC;
                    cnt_d   = LAT_M1;
                    addr_d  = bus.iDAddr;
                    wdat_d  = bus.iDWrData;
                    rd_d    = ~bus.iDWr;
                    wr_d    = bus.iDWr;
                    // count data grants that jumped ahead of a waiting fetch
                    if (if_req_m && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            ARB_IF_ACC, ARB_D_ACC: begin
                if (cnt_q == '0) begin
                    // memory data is valid in this last access cycle
                    if (rd_q) begin
                        if (state_q == ARB_IF_ACC) begin
                            if_dat_d = bus.iMemRdData;
                        end else begin
                            d_dat_d = bus.iMemRdData;
                        end
                    end
                    if_vld_d = (state_q == ARB_IF_ACC);
                    d_vld_d  = (state_q == ARB_D_ACC);
                    state_d  = ARB_IDLE;
                    addr_d   = '0;
                    wdat_d   = '0;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            if_dat_q <= '0;
            d_dat_q  <= '0;
            if_vld_q <= 1'b0;
            d_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            if_dat_q <= if_dat_d;
            d_dat_q  <= d_dat_d;
            if_vld_q <= if_vld_d;
            d_vld_q  <= d_vld_d;
        end
    end

    assign bus.oIfData    = if_dat_q;
    assign bus.oIfValid   = if_vld_q;
    assign bus.oIfStall   = bus.iIfReq & ~if_vld_q;
    assign bus.oDRdData   = d_dat_q;
    assign bus.oDValid    = d_vld_q;
    assign bus.oDStall    = bus.iDReq & ~d_vld_q;
    assign bus.oMemAddr   = addr_q;
    assign bus.oMemWrData = wdat_q;
    assign bus.oMemRd     = rd_q;
    assign bus.oMemWr     = wr_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported unified memory between the instruction-fetch port and the MEM-stage data port of the pipelined CPU. It issues one access at a time, holds each command for a fixed number of memory wait cycles, and returns read data or a write acknowledge. It drives per-port stall signals so the pipeline freezes while a port waits. The block sits between the IF/MEM stages and the memory model that replaces the separate instruction and data memories.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LAT`, 2, memory access cycles per transfer, legal range 1..15
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits, legal range 1..15

Ports (clock and reset first):
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `iIfReq`  in  1  fetch request; held with stable address until `oIfValid`
- `iIfAddr`  in  ADDR_W  fetch address
- `oIfData`  out  DATA_W  fetched word; held until next fetch completion
- `oIfValid`  out  1  one-cycle completion pulse, fetch port
- `oIfStall`  out  1  `iIfReq & ~oIfValid`
- `iDReq`  in  1  data request; held with stable address/data/write until `oDValid`
- `iDWr`  in  1  1 = write, 0 = read
- `iDAddr`  in  ADDR_W  data address
- `iDWrData`  in  DATA_W  store data
- `oDRdData`  out  DATA_W  load data; held until next data read completion
- `oDValid`  out  1  one-cycle completion pulse, data port (reads and writes)
- `oDStall`  out  1  `iDReq & ~oDValid`
- `oMemAddr`  out  ADDR_W  memory address
- `oMemWrData`  out  DATA_W  memory write data
- `oMemRd`  out  1  memory read strobe, held for the whole access
- `oMemWr`  out  1  memory write strobe, held for the whole access
- `iMemRdData`  in  DATA_W  memory read data; valid in the last access cycle

## Operation
- FSM states:
  - `IDLE`: arbitrate among unmasked requests.
    - Winner `IF`: go to `IF_ACC`.
    - Winner `D`: go to `D_ACC`.
    - No request: stay in `IDLE`.
  - `IF_ACC` / `D_ACC`: count down from `LAT-1`. On count 0, capture the result and return to `IDLE`.
- Masking: a port whose valid pulse is high in the current cycle has its request ignored that cycle, because the request is still held.
- Priority: the data port wins simultaneous requests, unless `starve == STARVE_MAX`; then fetch wins.
- Starvation counter `starve`:
  - Increments, saturating at `STARVE_MAX`, on each data grant while `iIfReq` is unmasked.
  - Clears on each fetch grant.
- Command registers: at grant, `oMemAddr`, `oMemWrData`, `oMemRd` and `oMemWr` load from the winning port.
  - A fetch is always a read, with `oMemWrData` = 0.
  - All four hold for exactly `LAT` cycles, then clear to 0 on return to `IDLE`.
- Completion: on the count-0 cycle, a read captures `iMemRdData` into `oIfData` or `oDRdData`. The port's valid pulse is registered at that same edge. A write captures nothing.
- Reset: `reset` high at any clock edge forces the following, regardless of state:
  - state `IDLE`, counter 0, `starve` 0
  - all outputs 0, including `oIfData` and `oDRdData`
  - any in-flight access is abandoned, and `oMemWr` drops at that edge.

## Timing
- Request seen in `IDLE` at cycle 0 → strobes high in cycles 1..LAT → valid pulse in cycle LAT+1, together with the `IDLE` re-arbitration.
- Back-to-back: the other port's pending request is granted in cycle LAT+1. Its strobes start in cycle LAT+2.
- One dead cycle between consecutive accesses. Throughput is one transfer per LAT+1 cycles.
- Stalls are combinational from the inputs and the registered valid pulse. There is no extra register stage.

## Structure
- Shared define header, alongside the existing width defines:
  - state encodings `ARB_IDLE` = 2'd0, `ARB_IF_ACC` = 2'd1, `ARB_D_ACC` = 2'd2
  - `MEM_LAT_DEF` = 2
  - `ARB_STARVE_DEF` = 4
- Single module, no sub-module. The starvation counter and the arbitration logic are small enough to live inline.

## Test plan
All scenarios use `LAT` = 2 and `STARVE_MAX` = 2.
- Fetch only: `iIfAddr` = 0x40 at cycle 0, memory returns 0x8C020004 → `oMemRd` high in cycles 1–2, `oIfValid` in cycle 3, `oIfData` = 0x8C020004, `oIfStall` high in cycles 0–2.
- Simultaneous requests: fetch 0x44 and data write 0x100 ← 0xDEAD at cycle 0 → data granted first, `oMemWr` high in cycles 1–2 with address 0x100; `oDValid` in cycle 3; fetch strobes in cycles 4–5; `oIfValid` in cycle 6.
- Starvation: `iIfReq` held and data requests back-to-back → after 2 data grants, fetch wins the third arbitration even with `iDReq` high; `starve` returns to 0.
- Request masking: data read held through its `oDValid` cycle and dropped the next cycle → exactly one memory read is issued for it.
- Reset mid-write: `reset` high in cycle 2 of a write → `oMemWr` = 0 in cycle 3, no `oDValid`; a new fetch issued afterward completes normally.
- Idle: no requests for 10 cycles → all strobes 0, state stays `IDLE`, outputs stable.
